// File: rtl/sky130_ef_ip__rc_osc_500k_mon.sv
// sky130_ef_ip__rc_osc_500k_mon: enables the RC oscillator, waits for it to settle,
// then counts its rising edges over a clk-timed gate window and flags out-of-range counts.
module sky130_ef_ip__rc_osc_500k_mon #(
  parameter int CNT_W         = 16,
  parameter int GATE_CYCLES   = 1000,
  parameter int SETTLE_CYCLES = 256,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             continuous,
  input  logic [CNT_W-1:0] lo_thresh,
  input  logic [CNT_W-1:0] hi_thresh,
  input  logic             osc_in,
  output logic             osc_ena,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] count,
  output logic             too_slow,
  output logic             too_fast
);
  localparam int TMR_MAX = GATE_CYCLES > SETTLE_CYCLES ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;
  state_t r_state, w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [TMR_W-1:0]       r_tmr;
  logic [CNT_W-1:0]       r_cnt;
  logic                   w_edge, w_settle_end, w_gate_end, w_enter_meas, w_run;
  assign w_edge       = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign w_settle_end = r_tmr == TMR_W'(SETTLE_CYCLES - 1);
  assign w_gate_end   = r_tmr == TMR_W'(GATE_CYCLES - 1);
  assign w_enter_meas = (w_next == MEASURE) && (r_state != MEASURE);
  assign w_run        = (r_state == w_next) && (r_state == SETTLE || r_state == MEASURE);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start        ? SETTLE  : IDLE;
      SETTLE:  w_next = w_settle_end ? MEASURE : SETTLE;
      MEASURE: w_next = w_gate_end   ? DONE    : MEASURE;
      DONE:    w_next = continuous   ? MEASURE : IDLE;
      default: w_next = IDLE;
    endcase
    if (stop) w_next = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], osc_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_tmr    <= '0;
      r_cnt    <= '0;
      osc_ena  <= 1'b0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      count    <= '0;
      too_slow <= 1'b0;
      too_fast <= 1'b0;
    end else begin
      r_state <= w_next;
      osc_ena <= w_next != IDLE;
      busy    <= w_next != IDLE;
      valid   <= 1'b0;
      r_tmr   <= w_run ? r_tmr + 1'b1 : '0;
      // saturate rather than wrap so a runaway oscillator still reads as too fast
      if (w_enter_meas) r_cnt <= '0;
      else if (r_state == MEASURE && w_edge && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      if (r_state == DONE && !stop) begin
        valid    <= 1'b1;
        count    <= r_cnt;
        too_slow <= r_cnt < lo_thresh;
        too_fast <= r_cnt > hi_thresh;
      end
    end
  end
endmodule

// File: tb/tb_sky130_ef_ip__rc_osc_500k_mon.sv
// tb_sky130_ef_ip__rc_osc_500k_mon: scoreboard bench; a 16-bit monitor at 10 MHz clk plus a
// 4-bit instance fed a fast oscillator to exercise count saturation.
module tb_sky130_ef_ip__rc_osc_500k_mon;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, cont = 1'b0;
  logic [15:0] lo = 16'd45, hi = 16'd55;
  logic        osc = 1'b0;
  logic        osc_ena, busy, valid, too_slow, too_fast;
  logic [15:0] count;
  logic        osc2 = 1'b0, start2 = 1'b0;
  logic        osc_ena2, busy2, valid2, too_slow2, too_fast2;
  logic [3:0]  count2;
  int          cyc = 0, checks = 0, errors = 0;
  int unsigned half_ps = 0;
  typedef struct {int cyc; int cnt; bit slow; bit fast;} exp_t;
  exp_t q[$], q2[$];

  sky130_ef_ip__rc_osc_500k_mon dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(cont),
    .lo_thresh(lo), .hi_thresh(hi), .osc_in(osc), .osc_ena(osc_ena), .busy(busy),
    .valid(valid), .count(count), .too_slow(too_slow), .too_fast(too_fast));

  sky130_ef_ip__rc_osc_500k_mon #(.CNT_W(4), .GATE_CYCLES(1000), .SETTLE_CYCLES(4)) dut_sat (
    .clk(clk), .rst(rst), .start(start2), .stop(1'b0), .continuous(1'b0),
    .lo_thresh(4'd0), .hi_thresh(4'd15), .osc_in(osc2), .osc_ena(osc_ena2), .busy(busy2),
    .valid(valid2), .count(count2), .too_slow(too_slow2), .too_fast(too_fast2));

  always #50ns clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // oscillator edges sit 17 ns after a clk edge so none land near a sampling instant
  always begin : osc_gen
    int unsigned h;
    osc = 1'b0;
    @(posedge clk);
    #17ns;
    h = half_ps;
    while (h != 0 && h == half_ps) begin
      #(h * 1ps);
      osc = ~osc;
    end
  end

  initial begin
    #17ns;
    forever #200ns osc2 = ~osc2;
  end

  always @(negedge clk) begin : mon
    exp_t e;
    if (valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid cyc=%0d count=%0d", cyc, count);
      end else begin
        e = q.pop_front();
        if (cyc != e.cyc || int'(count) != e.cnt || too_slow != e.slow || too_fast != e.fast) begin
          errors++;
          $display("FAIL valid actual cyc=%0d count=%0d slow=%0b fast=%0b expected cyc=%0d count=%0d slow=%0b fast=%0b",
                   cyc, count, too_slow, too_fast, e.cyc, e.cnt, e.slow, e.fast);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_sat
    exp_t e;
    if (valid2) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid_sat cyc=%0d count=%0d", cyc, count2);
      end else begin
        e = q2.pop_front();
        if (cyc != e.cyc || int'(count2) != e.cnt || too_slow2 != e.slow || too_fast2 != e.fast) begin
          errors++;
          $display("FAIL sat actual cyc=%0d count=%0d slow=%0b fast=%0b expected cyc=%0d count=%0d slow=%0b fast=%0b",
                   cyc, count2, too_slow2, too_fast2, e.cyc, e.cnt, e.slow, e.fast);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
    end
  endtask

  task automatic issue(input int n, input int c, input bit s, input bit f);
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < n; i++) q.push_back('{cyc + 1258 + i * 1001, c, s, f});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_size(input int sz, input int budget, input string name);
    int k = 0;
    while (q.size() > sz && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (q.size() > sz) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s actual=%0d pending expected=%0d", name, q.size(), sz);
      while (q.size() > sz) void'(q.pop_front());
    end
  endtask

  initial begin : wd
    #5ms;
    $display("FAIL watchdog actual=hung expected=finished");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_osc_ena", int'(osc_ena), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_count", int'(count), 0);
    chk("reset_flags", int'({too_slow, too_fast}), 0);
    rst = 1'b0;
    half_ps = 1000000;
    @(negedge clk);
    start2 = 1'b1;
    q2.push_back('{cyc + 1006, 15, 1'b0, 1'b0});
    @(negedge clk);
    start2 = 1'b0;
    issue(1, 50, 1'b0, 1'b0);
    wait_size(0, 1400, "nominal");
    @(negedge clk);
    chk("nominal_osc_ena_off", int'(osc_ena), 0);
    chk("nominal_busy_off", int'(busy), 0);
    half_ps = 1250000;
    issue(1, 40, 1'b1, 1'b0);
    wait_size(0, 1400, "400k");
    half_ps = 833333;
    issue(1, 60, 1'b0, 1'b1);
    wait_size(0, 1400, "600k");
    half_ps = 1000000;
    lo = 16'd50; hi = 16'd50;
    issue(1, 50, 1'b0, 1'b0);
    wait_size(0, 1400, "equal");
    lo = 16'd60; hi = 16'd40;
    issue(1, 50, 1'b1, 1'b1);
    wait_size(0, 1400, "crossed");
    lo = 16'd45; hi = 16'd55;
    half_ps = 0;
    issue(1, 0, 1'b1, 1'b0);
    wait_size(0, 1400, "osc_low");
    half_ps = 1000000;
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    chk("start_stop_busy", int'(busy), 0);
    chk("start_stop_osc_ena", int'(osc_ena), 0);
    issue(1, 50, 1'b0, 1'b0);
    repeat (500) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_size(0, 1400, "start_busy");
    cont = 1'b1;
    issue(3, 50, 1'b0, 1'b0);
    wait_size(2, 1400, "cont1");
    @(negedge clk);
    chk("cont_osc_ena_on", int'(osc_ena), 1);
    wait_size(1, 1100, "cont2");
    cont = 1'b0;
    wait_size(0, 1100, "cont3");
    @(negedge clk);
    chk("cont_end_osc_ena", int'(osc_ena), 0);
    cont = 1'b1;
    issue(1, 50, 1'b0, 1'b0);
    wait_size(0, 1400, "cont_stop");
    half_ps = 1250000;
    repeat (300) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0; cont = 1'b0;
    chk("stop_osc_ena", int'(osc_ena), 0);
    repeat (1500) @(negedge clk);
    chk("stop_count_kept", int'(count), 50);
    chk("stop_flags_kept", int'({too_slow, too_fast}), 0);
    chk("stop_busy", int'(busy), 0);
    half_ps = 1000000;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (600) @(negedge clk);
    #20ns rst = 1'b1;
    #1ns;
    chk("async_rst_osc_ena", int'(osc_ena), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_count", int'(count), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_osc_ena", int'(osc_ena), 0);
    issue(1, 50, 1'b0, 1'b0);
    wait_size(0, 1400, "post_rst");
    if (q2.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_sat actual=%0d pending expected=0", q2.size());
    end
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
